booth_r4_mul: RTL

- Parametrised radix-4 (modified Booth) sequential multiplier; next generation of the 16-bit radix-2 Booth unit.
- Retires two multiplier bits per cycle.
- Supports signed and unsigned operands via a per-operation mode bit.
- Provides a start/busy/done handshake with back-to-back operation.
- Sits beside datapath units as a multi-cycle arithmetic resource.

---
 rtl/booth_r4_mul.sv | 124 ++++++++++++
 1 files changed

// File: rtl/booth_r4_mul.sv
// Radix-4 (modified Booth) sequential multiplier.
// Operands are extended to WIDTH+2 bits, so the same signed recoder serves both
// signed and unsigned modes. Each CALC cycle retires two multiplier bits.
// Product register z holds the last result until the next done pulse.
module booth_r4_mul #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   x,
  input  logic [WIDTH-1:0]   y,
  input  logic               sign_mode,
  output logic [2*WIDTH-1:0] z,
  output logic               busy,
  output logic               done
);

  // Iterations cover the full WIDTH+2-bit extended multiplier.
  localparam int N     = WIDTH / 2 + 1;
  localparam int AW    = WIDTH + 4;   // accumulator high part, holds +/-2X
  localparam int MW    = WIDTH + 3;   // {y_ext, 1'b0}
  localparam int CNT_W = $clog2(N + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t                 state_q;
  state_t                 state_d;
  logic signed [AW-1:0]   xe_q;
  logic signed [AW-1:0]   acc_q;
  logic        [MW-1:0]   mreg_q;
  logic        [CNT_W-1:0] cnt_q;

  logic signed [AW-1:0]   sum;
  logic signed [AW-1:0]   acc_nx;
  logic        [MW-1:0]   mreg_nx;
  logic        [2*WIDTH-1:0] product;
  logic                   last_iter;

  // Booth recoding of the low triplet {b1,b0,b-1} into a partial-product term.
  function automatic logic signed [AW-1:0] booth_term(
    input logic        [2:0]    trip,
    input logic signed [AW-1:0] xv
  );
    logic signed [AW-1:0] t;
    case (trip)
      3'b001, 3'b010: t = xv;
      3'b011:         t = xv <<< 1;
      3'b100:         t = -(xv <<< 1);
      3'b101, 3'b110: t = -xv;
      default:        t = '0;
    endcase
    return t;
  endfunction

  // Add the recoded term, then arithmetic-shift {acc, mreg} right by two.
  always_comb begin
    sum       = acc_q + booth_term(mreg_q[2:0], xe_q);
    acc_nx    = {{2{sum[AW-1]}}, sum[AW-1:2]};
    mreg_nx   = {sum[1:0], mreg_q[MW-1:2]};
    // After all shifts the product sits one bit above the appended zero.
    product   = {acc_q[WIDTH-3:0], mreg_q[MW-1:1]};
    last_iter = (cnt_q == CNT_W'(N - 1));
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_CALC;
      ST_CALC: if (last_iter) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Operand load, iteration datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      xe_q   <= '0;
      acc_q  <= '0;
      mreg_q <= '0;
      cnt_q  <= '0;
      z      <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            xe_q   <= sign_mode ? {{4{x[WIDTH-1]}}, x} : {4'b0000, x};
            mreg_q <= sign_mode ? {{2{y[WIDTH-1]}}, y, 1'b0} : {2'b00, y, 1'b0};
            acc_q  <= '0;
            cnt_q  <= '0;
            busy   <= 1'b1;
          end
        end
        ST_CALC: begin
          acc_q  <= acc_nx;
          mreg_q <= mreg_nx;
          cnt_q  <= cnt_q + 1'b1;
        end
        ST_DONE: begin
          z    <= product;
          done <= 1'b1;
          busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
